// File: rtl/uart_tx_frame.sv
// Parametrised UART frame transmitter: one-deep holding register, runtime parity, STOP_BITS stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK/MAB line-break states.
//
// state  | meaning
// IDLE   | line high, waiting for a held word (or a break request)
// START  | start bit, line low
// DATA   | DATA_BITS data bits, LSB first
// PARITY | parity bit (skipped when parity_mode = 00)
// STOP   | STOP_BITS stop bits, line high
// BREAK  | line held low while break_req, minimum one parity frame
// MAB    | mark after break, line high for STOP_BITS bit periods
`timescale 1ns/1ps

module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 tx_clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_serial,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
`ifdef UART_TX_BREAK_EN
  // Minimum break: a full frame including a parity bit
  localparam int BRK_MIN = (2 + DATA_BITS + STOP_BITS) * CLKS_PER_BIT;
  localparam int BRK_W   = $clog2(BRK_MIN);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRK_MIN - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_MAB
`endif
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [IDX_W-1:0]     data_idx, data_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 par_en, par_en_n;
  logic [DATA_BITS-1:0] hold_data;
  logic [1:0]           hold_mode;
  logic                 hold_full;
  logic                 serial_n;
  logic                 load;
  logic                 pick_next;
  logic                 done;
  logic                 bit_end;
  logic                 accept;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]     brk_cnt, brk_cnt_n;
`endif

  assign accept   = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  assign tx_busy  = (state != S_IDLE) || hold_full;
  assign tx_done  = done;

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_mode <= 2'b00;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
      hold_mode <= parity_mode;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      data_idx  <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_en    <= 1'b0;
      tx_serial <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      data_idx  <= data_idx_n;
      stop_idx  <= stop_idx_n;
      shreg     <= shreg_n;
      par_bit   <= par_bit_n;
      par_en    <= par_en_n;
      tx_serial <= serial_n;
`ifdef UART_TX_BREAK_EN
      brk_cnt   <= brk_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    data_idx_n = data_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    par_en_n   = par_en;
    load       = 1'b0;
    pick_next  = 1'b0;
    done       = 1'b0;
    serial_n   = 1'b1;
    bit_end    = (bit_cnt == BIT_LAST);
`ifdef UART_TX_BREAK_EN
    brk_cnt_n  = brk_cnt;
`endif

    case (state)
      S_IDLE: pick_next = 1'b1;
      S_START: begin
        if (bit_end) begin
          state_n    = S_DATA;
          bit_cnt_n  = '0;
          data_idx_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (data_idx == DATA_LAST) begin
            state_n    = par_en ? S_PARITY : S_STOP;
            stop_idx_n = 1'b0;
          end else begin
            data_idx_n = data_idx + 1'b1;
            shreg_n    = shreg >> 1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n    = S_STOP;
          bit_cnt_n  = '0;
          stop_idx_n = 1'b0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (stop_idx == STOP_LAST) begin
            done      = 1'b1;
            pick_next = 1'b1;
          end else begin
            stop_idx_n = stop_idx + 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (brk_cnt != BRK_LAST) brk_cnt_n = brk_cnt + 1'b1;
        if (!break_req && (brk_cnt == BRK_LAST)) begin
          state_n    = S_MAB;
          bit_cnt_n  = '0;
          stop_idx_n = 1'b0;
        end
      end
      S_MAB: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (stop_idx == STOP_LAST) pick_next = 1'b1;
          else stop_idx_n = stop_idx + 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Frame boundary: break first, then a held word goes straight to START
    if (pick_next) begin
      state_n = S_IDLE;
`ifdef UART_TX_BREAK_EN
      if (break_req) begin
        state_n   = S_BREAK;
        brk_cnt_n = '0;
      end else
`endif
      if (hold_full) load = 1'b1;
    end

    if (load) begin
      state_n   = S_START;
      bit_cnt_n = '0;
      shreg_n   = hold_data;
      par_en_n  = (hold_mode != 2'b00);
      case (hold_mode)
        2'b01:   par_bit_n = ^hold_data;
        2'b10:   par_bit_n = ~^hold_data;
        2'b11:   par_bit_n = 1'b1;
        default: par_bit_n = 1'b0;
      endcase
    end

    case (state_n)
      S_START:  serial_n = 1'b0;
      S_DATA:   serial_n = shreg_n[0];
      S_PARITY: serial_n = par_bit_n;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  serial_n = 1'b0;
`endif
      default:  serial_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8-bit/1-stop and 7-bit/2-stop instances at 4 clocks per bit.
// Break scenario is included when UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps

module tb_uart_tx_frame;
  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic       reset_n;
  logic       a_valid, a_ready, a_busy, a_serial, a_done;
  logic [7:0] a_data;
  logic [1:0] a_mode;
  logic       b_valid, b_ready, b_busy, b_serial, b_done;
  logic [6:0] b_data;
  logic [1:0] b_mode;
`ifdef UART_TX_BREAK_EN
  logic       a_break, b_break;
`endif

  int checks = 0;
  int failures = 0;
  logic [127:0] cap_ser, cap_done, cap_rdy, cap_busy;
  logic [127:0] exp_v;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_valid(a_valid), .tx_data(a_data),
    .parity_mode(a_mode),
`ifdef UART_TX_BREAK_EN
    .break_req(a_break),
`endif
    .tx_ready(a_ready), .tx_busy(a_busy), .tx_serial(a_serial), .tx_done(a_done)
  );

  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_valid(b_valid), .tx_data(b_data),
    .parity_mode(b_mode),
`ifdef UART_TX_BREAK_EN
    .break_req(b_break),
`endif
    .tx_ready(b_ready), .tx_busy(b_busy), .tx_serial(b_serial), .tx_done(b_done)
  );

  // Records n cycles of outputs; sample 0 is taken at the current negedge
  task automatic capture(input int sel, input int n);
    cap_ser = '0; cap_done = '0; cap_rdy = '0; cap_busy = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge tx_clk);
      if (sel == 0) begin
        cap_ser[k] = a_serial; cap_done[k] = a_done; cap_rdy[k] = a_ready; cap_busy[k] = a_busy;
      end else begin
        cap_ser[k] = b_serial; cap_done[k] = b_done; cap_rdy[k] = b_ready; cap_busy[k] = b_busy;
      end
    end
  endtask

  // Line waveform for a bit string at 4 clocks per bit, idle high afterwards
  function automatic logic [127:0] expand(input string seq, input int n);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < n; k++)
      v[k] = (k / 4 < seq.len()) ? (seq.getc(k / 4) == 8'h31) : 1'b1;
    return v;
  endfunction

  task automatic send_a(input logic [7:0] d, input logic [1:0] m);
    a_valid = 1'b1; a_data = d; a_mode = m;
    @(posedge tx_clk);
    @(negedge tx_clk);
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge tx_clk);
    checks++; if (a_serial !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b want=1", a_serial); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", a_done); end
    reset_n = 1'b1;
    @(negedge tx_clk);
    capture(0, 12);
    exp_v = expand("", 12);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL idle_serial got=%h want=%h", cap_ser, exp_v); end
    checks++; if (cap_busy !== 128'd0) begin failures++; $display("FAIL idle_busy got=%h want=0", cap_busy); end
  endtask

  task automatic test_even_a5();
    @(negedge tx_clk);
    send_a(8'hA5, 2'b01);
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL a5_ready_after_accept got=%b want=0", a_ready); end
    checks++; if (a_serial !== 1'b1) begin failures++; $display("FAIL a5_serial_before_load got=%b want=1", a_serial); end
    @(negedge tx_clk);
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL a5_ready_after_load got=%b want=1", a_ready); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL a5_busy got=%b want=1", a_busy); end
    capture(0, 45);
    exp_v = expand("01010010101", 45);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL a5_serial got=%h want=%h", cap_ser, exp_v); end
    exp_v = 128'd1 << 43;
    checks++; if (cap_done !== exp_v) begin failures++; $display("FAIL a5_done got=%h want=%h", cap_done, exp_v); end
    checks++; if (cap_busy[44] !== 1'b0) begin failures++; $display("FAIL a5_busy_after got=%b want=0", cap_busy[44]); end
  endtask

  task automatic test_back_to_back();
    string s;
    send_a(8'h00, 2'b10);
    @(negedge tx_clk);
    fork
      capture(0, 89);
      begin
        repeat (10) @(negedge tx_clk);
        a_valid = 1'b1; a_data = 8'hFF; a_mode = 2'b10;
        @(negedge tx_clk);
        a_valid = 1'b0;
      end
    join
    s = {"00000000011", "01111111111"};
    exp_v = expand(s, 89);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL b2b_serial got=%h want=%h", cap_ser, exp_v); end
    exp_v = (128'd1 << 43) | (128'd1 << 87);
    checks++; if (cap_done !== exp_v) begin failures++; $display("FAIL b2b_done got=%h want=%h", cap_done, exp_v); end
    exp_v = '0;
    for (int k = 0; k < 89; k++) exp_v[k] = (k <= 10) || (k >= 44);
    checks++; if (cap_rdy !== exp_v) begin failures++; $display("FAIL b2b_ready got=%h want=%h", cap_rdy, exp_v); end
  endtask

  task automatic test_seven_two_stop();
    b_valid = 1'b1; b_data = 7'h55; b_mode = 2'b00;
    @(posedge tx_clk);
    @(negedge tx_clk);
    b_valid = 1'b0;
    @(negedge tx_clk);
    capture(1, 41);
    exp_v = expand("0101010111", 41);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL d7_serial got=%h want=%h", cap_ser, exp_v); end
    exp_v = 128'd1 << 39;
    checks++; if (cap_done !== exp_v) begin failures++; $display("FAIL d7_done got=%h want=%h", cap_done, exp_v); end
    checks++; if (cap_busy[39] !== 1'b1) begin failures++; $display("FAIL d7_busy_last got=%b want=1", cap_busy[39]); end
    checks++; if (cap_busy[40] !== 1'b0) begin failures++; $display("FAIL d7_busy_after got=%b want=0", cap_busy[40]); end
  endtask

  task automatic test_reset_midframe();
    send_a(8'h81, 2'b01);
    @(negedge tx_clk);
    a_valid = 1'b1; a_data = 8'h0F; a_mode = 2'b01;
    @(negedge tx_clk);
    a_valid = 1'b0;
    repeat (16) @(negedge tx_clk);
    checks++; if (a_serial !== 1'b0) begin failures++; $display("FAIL mid_data_bit3 got=%b want=0", a_serial); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (a_serial !== 1'b1) begin failures++; $display("FAIL mid_rst_serial got=%b want=1", a_serial); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b want=1", a_ready); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b want=0", a_done); end
    @(negedge tx_clk);
    reset_n = 1'b1;
    @(negedge tx_clk);
    capture(0, 12);
    exp_v = expand("", 12);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL held_lost_serial got=%h want=%h", cap_ser, exp_v); end
    checks++; if (cap_busy !== 128'd0) begin failures++; $display("FAIL held_lost_busy got=%h want=0", cap_busy); end
    send_a(8'h3C, 2'b11);
    @(negedge tx_clk);
    capture(0, 45);
    exp_v = expand("00011110011", 45);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL mark_serial got=%h want=%h", cap_ser, exp_v); end
    exp_v = 128'd1 << 43;
    checks++; if (cap_done !== exp_v) begin failures++; $display("FAIL mark_done got=%h want=%h", cap_done, exp_v); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    string s;
    a_valid = 1'b1; a_data = 8'hA5; a_mode = 2'b01; a_break = 1'b1;
    @(negedge tx_clk);
    a_valid = 1'b0;
    fork
      capture(0, 109);
      begin
        repeat (59) @(negedge tx_clk);
        a_break = 1'b0;
      end
    join
    s = {"000000000000000", "1", "01010010101"};
    exp_v = expand(s, 109);
    checks++; if (cap_ser !== exp_v) begin failures++; $display("FAIL brk_serial got=%h want=%h", cap_ser, exp_v); end
    exp_v = 128'd1 << 107;
    checks++; if (cap_done !== exp_v) begin failures++; $display("FAIL brk_done got=%h want=%h", cap_done, exp_v); end
    checks++; if (cap_busy[30] !== 1'b1 || cap_busy[62] !== 1'b1) begin
      failures++; $display("FAIL brk_busy got=%b%b want=11", cap_busy[30], cap_busy[62]);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b1;
    a_valid = 1'b0; a_data = '0; a_mode = 2'b00;
    b_valid = 1'b0; b_data = '0; b_mode = 2'b00;
`ifdef UART_TX_BREAK_EN
    a_break = 1'b0; b_break = 1'b0;
`endif
    test_reset();
    test_even_a5();
    test_back_to_back();
    test_seven_two_stop();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised successor to the fixed 8N1-plus-even-parity UART transmitter. It serialises DATA_BITS-wide words into asynchronous serial frames with runtime-selectable parity and compile-time stop-bit count. It runs from the system clock and times each bit with an internal divider, so no separate baud clock is needed. A one-deep holding register with a valid/ready handshake allows back-to-back frames with no idle gap; it sits between the TX FIFO read side and the pad.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- CLKS_PER_BIT, 16, tx_clk cycles per serial bit, legal >= 2
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- tx_clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- tx_valid  in  1  word offered on tx_data
- tx_data  in  DATA_BITS  word to send, LSB transmitted first
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1); sampled when the word is accepted
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready at a rising edge
- tx_busy  out  1  high when the FSM is not in IDLE, or the holding register is full
- tx_serial  out  1  registered serial line, idles high
- tx_done  out  1  one-cycle pulse on the last cycle of the last stop bit
- break_req  in  1  present only with UART_TX_BREAK_EN

## Operation
- Holding register: {data, parity_mode} plus hold_full flag. tx_ready = !hold_full. An accept sets hold_full. A load into the shifter clears it.
- FSM states: IDLE, START, DATA, PARITY, STOP (plus BREAK and MAB, see Configuration).
- IDLE -> START when hold_full. The load copies the holding register into the shifter and computes the parity bit.
- Parity is computed over DATA_BITS bits: even = ^data, odd = ~^data, mark = 1.
- START (0) -> DATA: DATA_BITS bits, LSB first.
- DATA -> PARITY if mode != 00, otherwise -> STOP.
- STOP: line high for STOP_BITS bit periods.
- At the end of STOP: if hold_full, go directly to START (load in the same cycle), otherwise go to IDLE.
- Bit counter counts 0..CLKS_PER_BIT-1 per bit. Data index counts 0..DATA_BITS-1 and stop index counts 0..STOP_BITS-1.
- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, hold empty, state IDLE, counters 0.
- Reset mid-frame: asynchronous assertion forces tx_serial high immediately. The frame in flight and any held word are discarded.

## Timing
- Accept at edge N with the FSM in IDLE: load at edge N+1, and tx_serial falls after edge N+1.
- tx_ready is low after edge N and high again after edge N+1.
- Every bit, including start, parity and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P is 0 when mode = 00 and 1 otherwise.
- Back-to-back frames: a word accepted at any point during the current frame starts on the cycle after the last stop-bit cycle, with zero idle cycles.
- Only one word can be pending. tx_ready stays low until that word is loaded.
- tx_done is high during the final cycle of the last stop bit, in both the IDLE-next and START-next cases.
- tx_valid with tx_ready low is ignored. The source must hold tx_data until the handshake completes.

## Configuration
- UART_TX_BREAK_EN defined:
  - break_req port exists.
  - In IDLE (or at the end of STOP), break_req=1 has priority over a held word and moves the FSM to BREAK.
  - In BREAK, tx_serial=0 for as long as break_req=1, with a minimum of one full frame length.
  - After break_req deasserts and the minimum has elapsed, the FSM enters MAB: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
  - tx_busy=1 throughout BREAK and MAB. tx_done does not pulse.
  - The holding register can still accept a word during BREAK/MAB.
- UART_TX_BREAK_EN undefined:
  - No break_req port and no BREAK/MAB states.
  - tx_serial is low only during start bits and 0-valued data or parity bits.

## Test plan
1. Reset: assert reset_n=0 mid-run -> immediately tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0. After release, no activity without tx_valid.
2. CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1. Send 0xA5 with even parity:
   - tx_serial sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles.
   - tx_done pulses at cycle 44 after the start bit begins.
3. Back-to-back with odd parity: send 0x00, then 0xFF accepted during the first frame's data bits.
   - Parity bits are 1 and 1.
   - The second start bit immediately follows the first stop bit with no gap.
   - tx_ready rises once after the second load.
4. DATA_BITS=7, STOP_BITS=2, mode 00. Send 0x55:
   - Frame is 0,1,0,1,0,1,0,1,1,1, lasting 40 cycles.
   - tx_busy falls the cycle after tx_done.
5. Reset during data bit 3 with a word held -> line high at once, held word lost. The next accepted 0x3C with mark parity transmits correctly.
6. With UART_TX_BREAK_EN, CLKS_PER_BIT=4, DATA_BITS=8, even parity, STOP_BITS=1. Hold break_req for 60 cycles while a word is pending:
   - tx_serial is low for 60 cycles, then high for 4 cycles.
   - The pending frame then starts.
   - tx_done does not pulse for the break.
